// File: rtl/rx_backend.sv
`default_nettype none
// ============================================================================
// Module   : rx_backend
// Brief    : UART receive back end. Decodes a sampled frame into data, a
//            framing flag and a parity flag, then queues the result in a
//            small receive FIFO with a sticky overrun flag.
//            Optional parity handling is built in when the macro
//            WBUART_RX_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module rx_backend #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [10:0] frame_i,
    input  logic        frame_valid_i,
    input  logic [1:0]  data_size_i,
    input  logic        parity_en_i,
    input  logic        parity_odd_i,
    input  logic        stop_bits_i,
    input  logic        rx_ack_i,
    input  logic        clear_err_i,
    output logic [7:0]  rx_data_o,
    output logic        rx_valid_o,
    output logic        frame_err_o,
    output logic        parity_err_o,
    output logic        overrun_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] c_ptr_one = {{AW{1'b0}}, 1'b1};

    // Decode stage registers
    logic        r_dec_valid;
    logic [10:0] r_frame;
    logic [1:0]  r_size;
    logic        r_stop2;

    // Decode results
    logic [3:0]  w_n;
    logic [3:0]  w_stop_idx;
    logic [7:0]  w_data;
    logic        w_p;
    logic        w_fe;
    logic        w_pe;

    // FIFO state: entry = {data[7:0], fe, pe}
    logic [9:0]  r_mem [FIFO_DEPTH];
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    logic        r_overrun;
    logic        w_empty;
    logic        w_full;
    logic        w_pop;
    logic        w_push;
    logic        w_drop;
    logic [9:0]  w_head;

`ifdef WBUART_RX_PARITY_EN
    logic        r_par_en;
    logic        r_par_odd;

    // Parity configuration is captured together with the frame
    always_ff @(posedge clk_i) begin
        if (frame_valid_i) begin
            r_par_en  <= parity_en_i;
            r_par_odd <= parity_odd_i;
        end
    end
`else
    // Parity inputs have no function in this build
    logic w_unused_parity;
    assign w_unused_parity = parity_en_i ^ parity_odd_i;
`endif

    // Decode valid flag; only this bit needs reset, the payload follows it
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_dec_valid <= 1'b0;
        end else begin
            r_dec_valid <= frame_valid_i;
        end
    end

    // Capture frame and configuration only on the strobe
    always_ff @(posedge clk_i) begin
        if (frame_valid_i) begin
            r_frame <= frame_i;
            r_size  <= data_size_i;
            r_stop2 <= stop_bits_i;
        end
    end

    // Split the registered frame into data, parity and stop fields
    always_comb begin
        w_n = 4'd5 + {2'b00, r_size};
        case (r_size)
            2'b00:   w_data = {3'b000, r_frame[4:0]};
            2'b01:   w_data = {2'b00,  r_frame[5:0]};
            2'b10:   w_data = {1'b0,   r_frame[6:0]};
            default: w_data = r_frame[7:0];
        endcase
`ifdef WBUART_RX_PARITY_EN
        w_p  = r_par_en;
        // Data bits above N-1 are already zero, so a full XOR reduction works
        w_pe = r_par_en & ((^w_data ^ r_frame[w_n]) != r_par_odd);
`else
        w_p  = 1'b0;
        w_pe = 1'b0;
`endif
        w_stop_idx = w_n + {3'b000, w_p};
        w_fe = ~r_frame[w_stop_idx] | (r_stop2 & ~r_frame[w_stop_idx + 4'd1]);
    end

    // FIFO status and push/pop qualification
    always_comb begin
        w_empty = (r_wptr == r_rptr);
        w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                  (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
        w_pop   = rx_ack_i & ~w_empty;
        // A pop in the same cycle frees the slot the push lands in
        w_push  = r_dec_valid & (~w_full | w_pop);
        w_drop  = r_dec_valid & w_full & ~w_pop;
        w_head  = r_mem[r_rptr[AW-1:0]];
    end

    // FIFO storage write, no reset needed
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= {w_data, w_fe, w_pe};
        end
    end

    // Read and write pointers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_ptr_one;
            end
        end
    end

    // Sticky overrun flag; a drop takes priority over a clear
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (clear_err_i) begin
            r_overrun <= 1'b0;
        end
    end

    // Head entry outputs are forced to zero while the FIFO is empty
    always_comb begin
        rx_valid_o   = ~w_empty;
        rx_data_o    = w_empty ? 8'h00 : w_head[9:2];
        frame_err_o  = ~w_empty & w_head[1];
        parity_err_o = ~w_empty & w_head[0];
        overrun_o    = r_overrun;
    end

endmodule
`default_nettype wire

// File: doc/rx_backend.md
RX_BACKEND -- requirements
Module: rx_backend

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, giving the receive FIFO entry count; legal values are powers of two from 2 to 16.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 The block SHALL have port clk_i, input, 1 bit: clock.
REQ-004 The block SHALL have port rst_i, input, 1 bit: synchronous active-high reset.
REQ-005 The block SHALL have port frame_i, input, 11 bits: sampled frame from the RX frontend; bit0 is the first bit after the start bit.
REQ-006 The block SHALL have port frame_valid_i, input, 1 bit: one-cycle strobe; frame_i is valid in that cycle.
REQ-007 The block SHALL have port data_size_i, input, 2 bits: data width, where 00=5, 01=6, 10=7 and 11=8 bits.
REQ-008 The block SHALL have port parity_en_i, input, 1 bit: a parity bit follows the data.
REQ-009 The block SHALL have port parity_odd_i, input, 1 bit: 1=odd parity, 0=even parity.
REQ-010 The block SHALL have port stop_bits_i, input, 1 bit: 0=one stop bit, 1=two stop bits.
REQ-011 The block SHALL have port rx_ack_i, input, 1 bit: consumer pops the head entry.
REQ-012 The block SHALL have port clear_err_i, input, 1 bit: clears the overrun flag.
REQ-013 The block SHALL have port rx_data_o, output, 8 bits: head entry data, zero-extended.
REQ-014 The block SHALL have port rx_valid_o, output, 1 bit: FIFO is not empty.
REQ-015 The block SHALL have port frame_err_o, output, 1 bit: head entry has a framing error.
REQ-016 The block SHALL have port parity_err_o, output, 1 bit: head entry has a parity error.
REQ-017 The block SHALL have port overrun_o, output, 1 bit: sticky flag, set when a frame is dropped.

Function
REQ-018 Decode stage: on frame_valid_i, the block SHALL register frame_i, data_size_i, parity_en_i, parity_odd_i and stop_bits_i; configuration changes on any other cycle SHALL have no effect on that frame.
REQ-019 Layout: with N data bits, data SHALL occupy bits [N-1:0], parity (when enabled) SHALL occupy bit N, and stop bits SHALL follow at bits N+P and, when two are configured, N+P+1, where P=1 if parity is present and 0 otherwise; remaining bits SHALL be ignored.
REQ-020 Data bits above N-1 SHALL be zero in the stored entry.
REQ-021 Framing error SHALL be set if any configured stop bit is 0.
REQ-022 Parity error SHALL be set when the XOR of the data bits and the parity bit is not equal to parity_odd_i.
REQ-023 Push: in the cycle after the decode stage, the entry {data[7:0], fe, pe} SHALL be written at the write pointer; rx_valid_o SHALL rise 2 cycles after frame_valid_i when the FIFO was previously empty.
REQ-024 Pop: rx_ack_i while rx_valid_o=1 SHALL advance the read pointer in that cycle; rx_ack_i while rx_valid_o=0 SHALL be ignored.
REQ-025 Pointers SHALL be log2(FIFO_DEPTH)+1 bits wide, wrap modulo 2*FIFO_DEPTH, and indicate full when their MSBs differ and their low bits are equal.
REQ-026 Simultaneous push and pop SHALL both take effect, including when the FIFO is full; the occupancy count SHALL be unchanged.
REQ-027 A push into a full FIFO with no pop in the same cycle SHALL drop the frame, leave the stored entries unchanged, and set overrun_o on the next cycle.
REQ-028 overrun_o SHALL remain set until clear_err_i is asserted; if an overrun and clear_err_i occur in the same cycle, set SHALL win.
REQ-029 When the FIFO is empty, rx_data_o, frame_err_o and parity_err_o SHALL be 0.
REQ-030 frame_valid_i strobes on consecutive cycles SHALL each be accepted, giving one entry per strobe.

Reset
REQ-031 Reset SHALL clear both pointers, the decode valid flag and overrun_o; all outputs SHALL read 0 in the cycle after reset.
REQ-032 Reset asserted mid-operation SHALL discard any in-flight decode result and all FIFO contents.
REQ-033 FIFO storage SHALL NOT require reset.

Configuration
REQ-034 Macro WBUART_RX_PARITY_EN defined: parity SHALL be handled per REQ-019 and REQ-022.
REQ-035 Macro WBUART_RX_PARITY_EN undefined: parity_en_i and parity_odd_i SHALL be ignored, P SHALL be 0, and parity_err_o SHALL be constant 0.

Verification
REQ-036 Test 8N1: data_size=11, frame_i=0x7A5 -> rx_data_o=0xA5, fe=0, pe=0, rx_valid_o high 2 cycles after the strobe.
REQ-037 Test 8E1 with macro defined: frame_i=0x2A5 -> 0xA5, pe=0; frame_i=0x3A5 -> pe=1; with parity_odd=1, frame_i=0x3A5 -> pe=0.
REQ-038 Test framing: 8N2, frame_i=0x2A5 -> fe=1; 5N1, frame_i=0x7F3 -> rx_data_o=0x13, fe=0.
REQ-039 Test overrun: 5 strobes with no ack, FIFO_DEPTH=4 -> 4 entries in order, 5th dropped, overrun_o=1 until clear_err_i, then 0.
REQ-040 Test full FIFO: push and ack in the same cycle -> occupancy stays 4, ordering is preserved, overrun_o=0.
REQ-041 Test reset: reset asserted 1 cycle after a strobe -> rx_valid_o=0, and the frame is never delivered.
